// File: rtl/i2s_frame_scheduler.sv
// i2s_frame_scheduler: paces decoder sample pairs into the I2S serializer.
// Irregular decoder pairs are buffered in a small FIFO. Exactly one pair is
// released per audio frame, together with a soft-ramped volume code. Prime and
// underflow handling keep the output silent until the FIFO has some slack.
module i2s_frame_scheduler #(
  parameter int IN_WIDTH     = 10,
  parameter int VOLUME_WIDTH = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_CLK    = 1536
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [IN_WIDTH-1:0]          s_left,
  input  logic signed [IN_WIDTH-1:0]          s_right,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [VOLUME_WIDTH-1:0]             target_volume,
  input  logic                                mute,
  output logic signed [IN_WIDTH-1:0]          out_left,
  output logic signed [IN_WIDTH-1:0]          out_right,
  output logic                                out_valid,
  output logic [VOLUME_WIDTH-1:0]             out_volume,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic [15:0]                         underflow_cnt
);

  localparam int VMAX  = (1 << VOLUME_WIDTH) - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (FRAME_CLK > 1) ? $clog2(FRAME_CLK) : 1;
  localparam int PAIR_W = 2 * IN_WIDTH;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Frame timing
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // FIFO storage and bookkeeping; each entry holds {left, right}
  logic [PAIR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PAIR_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [PAIR_W-1:0] head_pair;

  // Sequencer and output registers
  state_e                   state_q, state_d;
  logic signed [IN_WIDTH-1:0] out_left_q, out_left_d;
  logic signed [IN_WIDTH-1:0] out_right_q, out_right_d;
  logic                     out_valid_q, out_valid_d;
  logic [VOLUME_WIDTH-1:0]  out_volume_q, out_volume_d;
  logic [15:0]              underflow_q, underflow_d;
  logic [VOLUME_WIDTH-1:0]  goal;
  logic                     force_silence;

  // Handshake and event decode, all derived from registered state only
  always_comb begin
    tick       = (cnt_q == CNT_W'(FRAME_CLK - 1));
    s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    push       = s_valid && s_ready;
    pop        = tick && (state_q == RUN) && !fifo_empty;
    head_pair  = mem_q[rd_ptr_q];
  end

  // Free-running frame counter, wraps after FRAME_CLK cycles
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // FIFO write, read and occupancy; a simultaneous push and pop leaves level alone
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s_left, s_right};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Volume goal and the soft-mute silencing condition, both judged at the tick
  always_comb begin
    goal          = mute ? VOLUME_WIDTH'(VMAX) : target_volume;
    force_silence = mute && (out_volume_q == VOLUME_WIDTH'(VMAX));
  end

  // Prime/run sequencer: chooses the pair emitted at each tick and ramps volume
  always_comb begin
    state_d      = state_q;
    out_valid_d  = tick;
    out_left_d   = out_left_q;
    out_right_d  = out_right_q;
    out_volume_d = out_volume_q;
    underflow_d  = underflow_q;
    if (tick) begin
      out_left_d  = '0;
      out_right_d = '0;
      case (state_q)
        PRIME: begin
          if (level_q >= LVL_W'(FIFO_DEPTH / 2)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!fifo_empty) begin
            if (!force_silence) begin
              out_left_d  = head_pair[PAIR_W-1:IN_WIDTH];
              out_right_d = head_pair[IN_WIDTH-1:0];
            end
          end else begin
            state_d = PRIME;
            if (underflow_q != 16'hFFFF) begin
              underflow_d = underflow_q + 16'd1;
            end
          end
        end
        default: state_d = PRIME;
      endcase
      if (out_volume_q < goal) begin
        out_volume_d = out_volume_q + VOLUME_WIDTH'(1);
      end else if (out_volume_q > goal) begin
        out_volume_d = out_volume_q - VOLUME_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset; reset also flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      state_q      <= PRIME;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_valid_q  <= 1'b0;
      out_volume_q <= VOLUME_WIDTH'(VMAX);
      underflow_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      out_valid_q  <= out_valid_d;
      out_volume_q <= out_volume_d;
      underflow_q  <= underflow_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_left      = out_left_q;
  assign out_right     = out_right_q;
  assign out_valid     = out_valid_q;
  assign out_volume    = out_volume_q;
  assign fifo_level    = level_q;
  assign underflow_cnt = underflow_q;

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Paces stereo samples from the FM stereo decoder into the I2S serializer.
- Buffers irregularly arriving decoder samples in a small FIFO and emits exactly one sample pair per audio frame (clk / FRAME_CLK; 48 kHz at 73.728 MHz).
- Drives the serializer's in_valid, in_left, in_right and volume inputs.
- Provides soft mute and volume ramping, prime/underflow handling, and an underflow counter.

Parameters:
- IN_WIDTH, 10, sample width of each channel.
- VOLUME_WIDTH, 4, volume code width. Code 0 = loudest; VMAX = 2^VOLUME_WIDTH-1 = quietest.
- FIFO_DEPTH, 8, sample-pair FIFO depth. Must be a power of 2, ≥4.
- FRAME_CLK, 1536, clk cycles per audio frame.

Ports:
- clk  in  1  system clock, 73.728 MHz.
- reset  in  1  synchronous, active-high reset.
- s_left  in  IN_WIDTH  signed left sample from decoder.
- s_right  in  IN_WIDTH  signed right sample from decoder.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  FIFO can accept a pair.
- target_volume  in  VOLUME_WIDTH  requested volume code.
- mute  in  1  soft-mute request.
- out_left  out  IN_WIDTH  signed left sample to serializer.
- out_right  out  IN_WIDTH  signed right sample to serializer.
- out_valid  out  1  one-cycle frame strobe to serializer in_valid.
- out_volume  out  VOLUME_WIDTH  current ramped volume to serializer.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow_cnt  out  16  saturating count of underflow events.

Behaviour:
- Reset values:
  - out_left = out_right = 0, out_valid = 0, out_volume = VMAX, fifo_level = 0, underflow_cnt = 0.
  - Frame counter = 0, state = PRIME, FIFO empty.
  - s_ready is 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation flushes the FIFO and returns all registers to these values on the next edge.
- Frame counter:
  - Counts 0..FRAME_CLK-1, then wraps to 0.
  - tick = (count == FRAME_CLK-1).
  - Every tick produces out_valid = 1 for exactly the following cycle. out_valid is never high for two consecutive cycles.
  - out_left, out_right and out_volume update on that same edge and hold until the next tick.
- FIFO:
  - s_ready = (fifo_level != FIFO_DEPTH), decoded from registered state only.
  - Push occurs when s_valid && s_ready.
  - A pop is taken only on tick, in state RUN, with the FIFO non-empty.
  - Simultaneous push and pop: level unchanged; data ordering preserved.
  - Push while full: s_ready = 0, so nothing is accepted; upstream must hold.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- State machine (evaluated on tick only):
  - PRIME: emit a zero pair; no pop. If the level sampled at the tick is ≥ FIFO_DEPTH/2, go to RUN for the next tick.
  - RUN, FIFO non-empty: pop and emit the head pair.
  - RUN, FIFO empty: emit a zero pair, increment underflow_cnt (saturating at 0xFFFF), go to PRIME.
- Volume ramp (on tick):
  - goal = mute ? VMAX : target_volume.
  - out_volume steps by ±1 toward goal, at most one step per frame. It stays put when equal to goal.
  - Changes to target_volume between ticks are sampled only at ticks.
- Mute zeroing:
  - If mute = 1 and out_volume == VMAX at the tick, the emitted pair is forced to 0.
  - The pop still occurs, so the FIFO keeps draining and stays live.
- Arithmetic: samples pass through unmodified. Width is IN_WIDTH; there is no scaling in this block (shifting is done by the serializer).

Test Plan (bench overrides FRAME_CLK = 32, FIFO_DEPTH = 4):
- Reset, then idle for 100 cycles.
  - out_valid pulses at cycles 32, 64 and 96 after reset release, each exactly 1 cycle wide.
  - Pairs are all zero; state stays PRIME; underflow_cnt = 0.
- Push (100, -100) and (200, -200), then wait.
  - Level reaches 2 and the next tick emits zero (PRIME → RUN).
  - The following ticks emit (100, -100), then (200, -200).
  - The next tick emits zero, underflow_cnt = 1, and the state returns to PRIME.
- Hold s_valid high with incrementing data.
  - s_ready drops when level = 4.
  - A push coinciding with a tick pop keeps level at 4.
  - The output sequence is strictly incrementing with no gaps or duplicates.
- target_volume = 2 starting from reset (out_volume = 15).
  - out_volume steps down 14, 13, …, 2 over 13 consecutive ticks, then holds.
- mute = 1 from out_volume = 2 with data flowing.
  - out_volume climbs one step per tick to 15.
  - Non-zero pairs are output until out_volume reaches 15; all later pairs are 0 while level keeps draining.
  - Releasing mute ramps back to 2.
- Assert reset for 1 cycle mid-frame with FIFO level = 3 and out_volume = 5.
  - Next cycle: level = 0, out_volume = 15, outputs 0, and the frame counter restarts so the next out_valid comes 32 cycles later.
